dbg_mon_access_ctrl: RTL

DBG_MON_ACCESS_CTRL -- requirements
Module: dbg_mon_access_ctrl

---
 rtl/dbg_mon_access_ctrl_pkg.sv | 10 +
 rtl/dbg_mon_ram.sv | 32 +++
 rtl/dbg_mon_access_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/dbg_mon_access_ctrl_pkg.sv
// dbg_mon_access_ctrl_pkg: shared FSM states, jdo field positions and error pattern
package dbg_mon_access_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR} state_t;
  localparam int RD_BIT = 35;
  localparam int ADDR_MSB = 33;
  localparam int ADDR_LSB = 24;
  localparam int DATA_MSB = 34;
  localparam int DATA_LSB = 3;
  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;
endpackage

// File: rtl/dbg_mon_ram.sv
// dbg_mon_ram: DEPTH x 32 RAM, one write port, two registered read ports (out-of-range reads return 0)
module dbg_mon_ram #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re_a,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [31:0]       o_rdata_a,
  input  logic              i_re_b,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [31:0]       o_rdata_b
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] r_mem [DEPTH];
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction
  // Reads sample the array before the write lands, so a same-cycle read sees old data
  always_ff @(posedge clk) begin
    if (i_we && in_range(i_waddr)) r_mem[i_waddr[AW-1:0]] <= i_wdata;
    if (i_re_a) o_rdata_a <= in_range(i_raddr_a) ? r_mem[i_raddr_a[AW-1:0]] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) o_rdata_b <= '0;
    else if (i_re_b) o_rdata_b <= in_range(i_raddr_b) ? r_mem[i_raddr_b[AW-1:0]] : '0;
  end
endmodule

// File: rtl/dbg_mon_access_ctrl.sv
// dbg_mon_access_ctrl: debug-slave access sequencer for the monitor RAM with an independent CPU read port
module dbg_mon_access_ctrl
  import dbg_mon_access_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  output logic [31:0]       cpu_readdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata, w_ram_q;
  logic r_error;
  logic w_idle, w_any, w_multi, w_rd_cmd, w_oor, w_we, w_set, w_clr, w_unused;
  assign w_unused = ^{jdo[37:36], jdo[2:0]};
  always_comb begin
    w_idle = r_state == IDLE;
    w_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    w_multi = (take_action_ocimem_a & take_no_action_ocimem_a) | (take_action_ocimem_a & take_action_ocimem_b) |
              (take_no_action_ocimem_a & take_action_ocimem_b);
    w_rd_cmd = !take_action_ocimem_b && (take_action_ocimem_a ? jdo[RD_BIT] : take_no_action_ocimem_a);
    w_oor = {1'b0, r_addr} >= (ADDR_W+1)'(DEPTH);
    w_next = r_state == RD_WAIT ? RD_DONE : !w_idle ? IDLE : take_action_ocimem_b ? WR : w_rd_cmd ? RD_WAIT : IDLE;
    w_we = r_state == WR && !reset && !w_oor;
    // Busy or colliding strobes and out-of-range completions raise the flag; a clean accept clears it
    w_set = (w_any && (!w_idle || w_multi)) || ((r_state == RD_DONE || r_state == WR) && w_oor);
    w_clr = w_idle && w_any && !w_multi;
    monitor_ready = w_idle;
    monitor_error = r_error;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_wdata <= '0;
      r_error <= 1'b0;
      MonDReg <= '0;
    end else begin
      r_state <= w_next;
      r_error <= w_set ? 1'b1 : w_clr ? 1'b0 : r_error;
      if (w_idle && take_action_ocimem_b) r_wdata <= jdo[DATA_MSB:DATA_LSB];
      if (r_state == WR || (w_idle && !take_action_ocimem_b && !take_action_ocimem_a && take_no_action_ocimem_a))
        r_addr <= r_addr + ADDR_W'(1);
      else if (w_idle && !take_action_ocimem_b && take_action_ocimem_a)
        r_addr <= ADDR_W'(jdo[ADDR_MSB:ADDR_LSB]);
      if (r_state == RD_DONE) MonDReg <= w_oor ? ERR_PATTERN : w_ram_q;
    end
  end
  dbg_mon_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(reset),
    .i_we(w_we),
    .i_waddr(r_addr),
    .i_wdata(r_wdata),
    .i_re_a(r_state == RD_WAIT),
    .i_raddr_a(r_addr),
    .o_rdata_a(w_ram_q),
    .i_re_b(cpu_read),
    .i_raddr_b(cpu_address),
    .o_rdata_b(cpu_readdata)
  );
endmodule
